// File: rtl/gtech_arb8_pkg.sv
// Shared constants, FSM state type and one-hot helper for the gtech_arb8_rr
// round-robin arbiter and its pick sub-block.
package gtech_arb8_pkg;

    localparam int ARB8_N   = 8;
    localparam int ARB8_IDW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb8_state_t;

    function automatic logic [ARB8_N-1:0] arb8_onehot(input logic [ARB8_IDW-1:0] idx);
        logic [ARB8_N-1:0] v;
        v = {{(ARB8_N-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/gtech_rr_pick8.sv
// Combinational round-robin pick: rotate REQ so PTR lands on bit 0, take the
// lowest set bit, then rotate the index back into requester numbering.
module gtech_rr_pick8
    import gtech_arb8_pkg::*;
(
    input  logic [ARB8_N-1:0]   REQ,
    input  logic [ARB8_IDW-1:0] PTR,
    output logic                ANY,
    output logic [ARB8_IDW-1:0] WIN
);

    logic [ARB8_N-1:0]   rot_s;
    logic [ARB8_IDW-1:0] off_s;

    // Bit j of rot_s is REQ[(PTR + j) mod 8]; a shift by 8 yields zero when PTR is 0.
    assign rot_s = (REQ >> PTR) | (REQ << (4'd8 - {1'b0, PTR}));

    // Lowest set bit of the rotated vector (scan high to low so the lowest wins).
    always_comb begin
        off_s = {ARB8_IDW{1'b0}};
        for (int i = ARB8_N - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? ARB8_IDW'(i) : off_s;
        end
    end

    assign ANY = |REQ;
    assign WIN = PTR + off_s;

endmodule

// File: rtl/gtech_arb8_rr.sv
// Eight-way round-robin arbiter with registered one-hot grant and a NOR8 idle flag.
// Optional forced release after MAX_HOLD cycles when GTECH_ARB8_TIMEOUT_EN is defined.
module gtech_arb8_rr
    import gtech_arb8_pkg::*;
#(
    parameter int NREQ     = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ,
    output logic [NREQ-1:0]     GNT,
    output logic [ARB8_IDW-1:0] GNT_ID,
    output logic                VALID,
    output logic                IDLE,
    output logic                TIMEOUT
);

    arb8_state_t         state_q, state_d;
    logic [ARB8_IDW-1:0] ptr_q, ptr_d;
    logic [ARB8_IDW-1:0] id_q, id_d;
    logic [ARB8_N-1:0]   gnt_q, gnt_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic                any_s;
    logic [ARB8_IDW-1:0] win_s;
    logic                cur_req_s;
    logic                force_s;

    gtech_rr_pick8 u_pick (
        .REQ (REQ),
        .PTR (ptr_q),
        .ANY (any_s),
        .WIN (win_s)
    );

    assign cur_req_s = REQ[id_q];

`ifdef GTECH_ARB8_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;

    // Tenure counter: zero on entry to a grant, counts every granted cycle.
    always_comb begin
        hold_d = hold_q;
        if (state_q == ST_IDLE) begin
            hold_d = 8'd0;
        end else if (state_q == ST_GRANT) begin
            hold_d = hold_q + 8'd1;
        end else begin
            hold_d = hold_q;
        end
    end

    // Tenure counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign force_s = (state_q == ST_GRANT) && (hold_q == HOLD_LAST);
`else
    assign force_s = 1'b0;
`endif

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    state_d = ST_GRANT;
                    gnt_d   = arb8_onehot(win_s);
                    id_d    = win_s;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A requester that drops on the limit cycle releases normally, no pulse.
                if (!cur_req_s || force_s) begin
                    state_d   = ST_GAP;
                    gnt_d     = {ARB8_N{1'b0}};
                    valid_d   = 1'b0;
                    ptr_d     = id_q + 3'd1;
                    timeout_d = force_s && cur_req_s;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {ARB8_N{1'b0}};
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd0;
            id_q      <= 3'd0;
            gnt_q     <= 8'h00;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign GNT     = gnt_q;
    assign GNT_ID  = id_q;
    assign VALID   = valid_q;
    assign TIMEOUT = timeout_q;
    assign IDLE    = ~|REQ;

endmodule

// File: tb/tb_gtech_arb8_rr.sv
// Self-checking bench for gtech_arb8_rr: directed scenarios plus randomized
// traffic, all compared against a behavioural round-robin model.
module tb_gtech_arb8_rr;

`ifdef GTECH_ARB8_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAXH = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] REQ;
    logic [7:0] GNT;
    logic [2:0] GNT_ID;
    logic       VALID;
    logic       IDLE;
    logic       TIMEOUT;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: who holds the grant, where the rotation resumes, pulse flag.
    logic       m_valid;
    logic       m_gap;
    logic       m_to;
    logic [2:0] m_id;
    logic [2:0] m_ptr;
    int         m_hold;

    gtech_arb8_rr #(.NREQ(8), .MAX_HOLD(MAXH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .GNT     (GNT),
        .GNT_ID  (GNT_ID),
        .VALID   (VALID),
        .IDLE    (IDLE),
        .TIMEOUT (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic model_step(input logic [7:0] r, input logic rst);
        bit limit;
        int idx;
        if (rst) begin
            m_valid = 1'b0; m_gap = 1'b0; m_to = 1'b0;
            m_id = 3'd0; m_ptr = 3'd0; m_hold = 0;
        end else begin
            m_to = 1'b0;
            if (m_valid) begin
                limit = TO_EN && (m_hold == MAXH - 1);
                if (!r[m_id] || limit) begin
                    m_to    = limit && r[m_id];
                    m_valid = 1'b0;
                    m_gap   = 1'b1;
                    m_ptr   = 3'((int'(m_id) + 1) % 8);
                end else begin
                    m_hold++;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    idx = (int'(m_ptr) + k) % 8;
                    if (r[idx]) begin
                        m_id = 3'(idx); m_valid = 1'b1; m_hold = 0;
                        break;
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_gnt();
        return m_valid ? (8'h01 << m_id) : 8'h00;
    endfunction

    task automatic cyc(input logic [7:0] r, input logic rst);
        REQ = r;
        RST = rst;
        @(posedge CLK);
        model_step(r, rst);
        #1;
    endtask

    task automatic do_reset();
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(8'hFF, 1'b1);
            n_tests++;
            if (GNT !== 8'h00 || VALID !== 1'b0 || TIMEOUT !== 1'b0 || IDLE !== 1'b0 || GNT_ID !== 3'd0) begin
                n_fail++;
                $display("FAIL reset: GNT=%h VALID=%b TO=%b IDLE=%b ID=%0d, expected 00/0/0/0/0",
                         GNT, VALID, TIMEOUT, IDLE, GNT_ID);
            end
        end
        cyc(8'hFF, 1'b0);
        n_tests++;
        if (GNT !== 8'h01 || VALID !== 1'b1 || GNT_ID !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: GNT=%h VALID=%b ID=%0d, expected 01/1/0", GNT, VALID, GNT_ID);
        end
    endtask

    task automatic test_rotation();
        int   ten;
        bit   prev_v;
        int   grants[$];
        logic [7:0] r;
        do_reset();
        ten = 0;
        prev_v = 1'b0;
        for (int c = 0; c < 300 && grants.size() < 9; c++) begin
            r = 8'hFF;
            if (m_valid) begin
                ten++;
                if (ten == 2) begin
                    r = 8'hFF & ~(8'h01 << m_id);
                    ten = 0;
                end
            end
            cyc(r, 1'b0);
            n_tests++;
            if (GNT !== exp_gnt() || VALID !== m_valid || GNT_ID !== m_id || TIMEOUT !== m_to) begin
                n_fail++;
                $display("FAIL rotation_cycle: GNT=%h VALID=%b ID=%0d TO=%b, expected %h/%b/%0d/%b",
                         GNT, VALID, GNT_ID, TIMEOUT, exp_gnt(), m_valid, m_id, m_to);
            end
            if (VALID === 1'b1 && !prev_v) grants.push_back(int'(GNT_ID));
            prev_v = (VALID === 1'b1);
        end
        n_tests++;
        if (grants.size() != 9) begin
            n_fail++;
            $display("FAIL rotation_count: got %0d grants, expected 9", grants.size());
        end
        for (int k = 0; k < grants.size(); k++) begin
            n_tests++;
            if (grants[k] != k % 8) begin
                n_fail++;
                $display("FAIL rotation_order: grant %0d went to %0d, expected %0d", k, grants[k], k % 8);
            end
        end
    endtask

    task automatic test_wrap_skip();
        logic [7:0] seq [8] = '{8'h20, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05, 8'h05};
        do_reset();
        foreach (seq[i]) begin
            cyc(seq[i], 1'b0);
            n_tests++;
            if (GNT !== exp_gnt() || VALID !== m_valid || GNT_ID !== m_id || TIMEOUT !== m_to) begin
                n_fail++;
                $display("FAIL wrap_cycle%0d: GNT=%h VALID=%b ID=%0d, expected %h/%b/%0d",
                         i, GNT, VALID, GNT_ID, exp_gnt(), m_valid, m_id);
            end
            if (i == 3) begin
                n_tests++;
                if (GNT !== 8'h01 || GNT_ID !== 3'd0) begin
                    n_fail++;
                    $display("FAIL wrap_from_ptr6: GNT=%h ID=%0d, expected 01/0", GNT, GNT_ID);
                end
            end
        end
        n_tests++;
        if (GNT !== 8'h04 || GNT_ID !== 3'd2) begin
            n_fail++;
            $display("FAIL skip_to_2: GNT=%h ID=%0d, expected 04/2", GNT, GNT_ID);
        end
    endtask

    task automatic test_mid_grant();
        logic [7:0] seq [7] = '{8'h08, 8'hF8, 8'hF8, 8'hF8, 8'hF0, 8'hF0, 8'hF0};
        do_reset();
        foreach (seq[i]) begin
            cyc(seq[i], 1'b0);
            n_tests++;
            if (GNT !== exp_gnt() || VALID !== m_valid || GNT_ID !== m_id || IDLE !== (seq[i] == 8'h00)) begin
                n_fail++;
                $display("FAIL mid_grant%0d: GNT=%h VALID=%b ID=%0d IDLE=%b, expected %h/%b/%0d",
                         i, GNT, VALID, GNT_ID, IDLE, exp_gnt(), m_valid, m_id);
            end
            if (i >= 1 && i <= 3) begin
                n_tests++;
                if (GNT !== 8'h08) begin
                    n_fail++;
                    $display("FAIL mid_grant_hold: GNT=%h, expected 08", GNT);
                end
            end
        end
        n_tests++;
        if (GNT !== 8'h10) begin
            n_fail++;
            $display("FAIL mid_grant_next: GNT=%h, expected 10", GNT);
        end
    endtask

    task automatic test_timeout();
        int  held;
        bit  dropped;
        int  pulses;
        do_reset();
        held = 0; dropped = 1'b0; pulses = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(8'h02, 1'b0);
            n_tests++;
            if (GNT !== exp_gnt() || VALID !== m_valid || TIMEOUT !== m_to || GNT_ID !== m_id) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: GNT=%h VALID=%b TO=%b, expected %h/%b/%b",
                         c, GNT, VALID, TIMEOUT, exp_gnt(), m_valid, m_to);
            end
            if (GNT === 8'h02 && !dropped) held++;
            else if (held > 0) dropped = 1'b1;
            if (TIMEOUT === 1'b1) pulses++;
        end
        n_tests++;
        if (held != (TO_EN ? MAXH : 20)) begin
            n_fail++;
            $display("FAIL timeout_tenure: held %0d cycles, expected %0d", held, TO_EN ? MAXH : 20);
        end
        n_tests++;
        if (!TO_EN && pulses != 0) begin
            n_fail++;
            $display("FAIL timeout_disabled: %0d pulses, expected 0", pulses);
        end else if (TO_EN && pulses == 0) begin
            n_fail++;
            $display("FAIL timeout_pulse: 0 pulses, expected at least 1");
        end
        // Requester drops exactly on the limit cycle: plain release, no pulse.
        do_reset();
        cyc(8'h02, 1'b0);
        cyc(8'h02, 1'b0);
        cyc(8'h02, 1'b0);
        cyc(8'h02, 1'b0);
        cyc(8'h00, 1'b0);
        n_tests++;
        if (GNT !== 8'h00 || TIMEOUT !== 1'b0 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_same_cycle_drop: GNT=%h TO=%b VALID=%b, expected 00/0/0", GNT, TIMEOUT, VALID);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(8'h20, 1'b0);
        cyc(8'h20, 1'b0);
        cyc(8'h20, 1'b1);
        n_tests++;
        if (GNT !== 8'h00 || TIMEOUT !== 1'b0 || VALID !== 1'b0 || GNT_ID !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_drop: GNT=%h TO=%b VALID=%b ID=%0d, expected 00/0/0/0",
                     GNT, TIMEOUT, VALID, GNT_ID);
        end
        cyc(8'h20, 1'b0);
        n_tests++;
        if (GNT !== 8'h20 || GNT_ID !== 3'd5 || VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: GNT=%h ID=%0d VALID=%b, expected 20/5/1", GNT, GNT_ID, VALID);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       rst;
        r = 8'h00;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(1, 0) == 0) r = 8'($urandom);
            rst = ($urandom_range(63, 0) == 0);
            cyc(r, rst);
            n_tests++;
            if (GNT !== exp_gnt() || VALID !== m_valid || GNT_ID !== m_id || TIMEOUT !== m_to ||
                IDLE !== (r == 8'h00) || $countones(GNT) > 1) begin
                n_fail++;
                $display("FAIL random_cycle%0d: REQ=%h GNT=%h VALID=%b ID=%0d TO=%b IDLE=%b, expected %h/%b/%0d/%b/%b",
                         c, r, GNT, VALID, GNT_ID, TIMEOUT, IDLE, exp_gnt(), m_valid, m_id, m_to, (r == 8'h00));
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        REQ = 8'hFF;
        model_step(8'h00, 1'b1);
        test_reset();
        test_rotation();
        test_wrap_skip();
        test_mid_grant();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
